// File: rtl/cw_key_shaper.sv
// CW keying envelope shaper: synchronises and debounces the key, sequences T/R,
// ramps the transmit envelope linearly and scales it by the requested power level.
module cw_key_shaper #(
    parameter int unsigned DEBOUNCE_CNT = 50,
    parameter int unsigned TR_DELAY     = 300,
    parameter int unsigned STEP         = 64,
    parameter int unsigned ENV_MAX      = 32767,
    parameter int unsigned HANG_CNT     = 20000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cw,
    input  logic        enable,
    input  logic [7:0]  tx_level,
    output logic [15:0] amplitude,
    output logic        tx_active,
    output logic        keyed,
    output logic        ramping
);

    localparam int unsigned ENV_W   = 16;
    localparam int unsigned LVL_W   = 8;
    localparam int unsigned PROD_W  = ENV_W + LVL_W + 1;
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CNT + 1);
    localparam int unsigned CNT_MAX = (HANG_CNT > TR_DELAY) ? HANG_CNT : TR_DELAY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        RISE  = 3'd2,
        HOLD  = 3'd3,
        FALL  = 3'd4,
        HANG  = 3'd5
    } state_t;

    logic              cw_meta;
    logic              cw_sync;
    logic [DB_W-1:0]   db_cnt;

    state_t            state;
    state_t            state_nxt;
    logic [ENV_W-1:0]  env;
    logic [ENV_W-1:0]  env_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic [ENV_W-1:0]  env_up_c;
    logic [ENV_W-1:0]  env_up_sat_c;
    logic [ENV_W-1:0]  env_dn_c;
    logic [LVL_W:0]    lvl_c;
    logic [PROD_W-1:0] prod_c;

    // Key synchroniser and debounce; keyed flips only after a stable run
    always_ff @(posedge clock) begin
        if (reset) begin
            cw_meta <= 1'b0;
            cw_sync <= 1'b0;
            keyed   <= 1'b0;
            db_cnt  <= '0;
        end else begin
            cw_meta <= cw;
            cw_sync <= cw_meta;
            if (cw_sync != keyed) begin
                if (db_cnt == DB_W'(DEBOUNCE_CNT - 1)) begin
                    keyed  <= ~keyed;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Saturating ramp steps; the last step is clipped to land exactly on the rail
    assign env_up_c     = env + ENV_W'(STEP);
    assign env_up_sat_c = (env_up_c >= ENV_W'(ENV_MAX)) ? ENV_W'(ENV_MAX) : env_up_c;
    assign env_dn_c     = (env <= ENV_W'(STEP)) ? '0 : env - ENV_W'(STEP);

    assign lvl_c  = {1'b0, tx_level} + (LVL_W + 1)'(1);
    assign prod_c = PROD_W'(env) * PROD_W'(lvl_c);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            env       <= '0;
            cnt       <= '0;
            tx_active <= 1'b0;
            ramping   <= 1'b0;
            amplitude <= '0;
        end else begin
            state     <= state_nxt;
            env       <= env_nxt;
            cnt       <= cnt_nxt;
            tx_active <= (state_nxt != IDLE);
            ramping   <= (state_nxt == RISE) || (state_nxt == FALL);
            amplitude <= ENV_W'(prod_c >> LVL_W);
        end
    end

    // Envelope sequencer; enable loss outranks key activity in every state
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                env_nxt = '0;
                cnt_nxt = '0;
                if (keyed && enable) begin
                    state_nxt = DELAY;
                end
            end
            DELAY: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!keyed) begin
                    state_nxt = HANG;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(TR_DELAY - 1)) begin
                    state_nxt = RISE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RISE: begin
                if (!enable || !keyed) begin
                    state_nxt = FALL;
                end else begin
                    env_nxt = env_up_sat_c;
                    if (env_up_sat_c == ENV_W'(ENV_MAX)) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                env_nxt = ENV_W'(ENV_MAX);
                if (!enable || !keyed) begin
                    state_nxt = FALL;
                end
            end
            FALL: begin
                if (keyed && enable) begin
                    state_nxt = RISE;
                end else begin
                    env_nxt = env_dn_c;
                    if (env_dn_c == '0) begin
                        state_nxt = enable ? HANG : IDLE;
                        cnt_nxt   = '0;
                    end
                end
            end
            HANG: begin
                env_nxt = '0;
                if (!enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (keyed) begin
                    state_nxt = RISE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(HANG_CNT - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                env_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cw_key_shaper.sv
// Self-checking bench for cw_key_shaper: level-scaling vector table plus a
// per-cycle amplitude scoreboard for rise, fall, re-key and enable-drop sequences.
module tb_cw_key_shaper;

    logic        clock = 1'b0;
    logic        reset;
    logic        cw;
    logic        enable;
    logic [7:0]  tx_level;
    logic [15:0] amplitude;
    logic        tx_active;
    logic        keyed;
    logic        ramping;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   amp;
        logic ramp;
        logic txa;
    } exp_t;

    typedef struct {
        logic [7:0] level;
        int         amp;
        logic       txa;
    } lvl_vec_t;

    exp_t     sb_q[$];
    lvl_vec_t tbl[7];

    cw_key_shaper dut (
        .clock     (clock),
        .reset     (reset),
        .cw        (cw),
        .enable    (enable),
        .tx_level  (tx_level),
        .amplitude (amplitude),
        .tx_active (tx_active),
        .keyed     (keyed),
        .ramping   (ramping)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return keyed;
            1:       return tx_active;
            default: return ramping;
        endcase
    endfunction

    // Count cycles until the selected output reaches val (bounded)
    task automatic wait_for(input string name, input int sel, input logic val,
                            input int bound, input int exp_n);
        int n = 0;
        while (sig(sel) !== val && n < bound) begin
            step();
            n++;
        end
        check(name, n, exp_n);
    endtask

    // Expected envelope after edge k of a sequence (k=0: edge where ramping rose)
    function automatic int exp_env(input int mode, input int k);
        int e;
        case (mode)
            0: begin
                e = 64 * k;
                if (e > 32767) e = 32767;
            end
            1: begin
                e = 32767 - 64 * k;
                if (e < 0) e = 0;
            end
            2: begin
                if (k <= 300)      e = 64 * k;
                else if (k <= 351) e = 19200 - 64 * (k - 301);
                else               e = 16000 + 64 * (k - 352);
            end
            default: begin
                if (k <= 128)      e = 64 * k;
                else if (k <= 257) e = 8192 - 64 * (k - 129);
                else               e = 0;
            end
        endcase
        return e;
    endfunction

    function automatic logic exp_ramp(input int mode, input int k);
        case (mode)
            0, 1:    return k < 512;
            2:       return 1'b1;
            default: return k < 257;
        endcase
    endfunction

    function automatic logic exp_txa(input int mode, input int k);
        if (mode == 3) return k < 257;
        return 1'b1;
    endfunction

    // Scoreboard run: push expectation with stimulus, pop when the DUT responds
    task automatic run_sb(input string name, input int mode, input int n);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            if (mode == 2 && k - 1 == 248) cw = 1'b0;
            if (mode == 2 && k - 1 == 299) cw = 1'b1;
            if (mode == 3 && k - 1 == 128) enable = 1'b0;
            e.amp  = exp_env(mode, k - 1);
            e.ramp = exp_ramp(mode, k);
            e.txa  = exp_txa(mode, k);
            sb_q.push_back(e);
            step();
            e = sb_q.pop_front();
            check({name, "_amp"}, int'(amplitude), e.amp);
            check({name, "_ramping"}, int'(ramping), int'(e.ramp));
            check({name, "_tx_active"}, int'(tx_active), int'(e.txa));
        end
    endtask

    initial begin
        int   seen;
        tbl[0] = '{8'd255, 32767, 1'b1};
        tbl[1] = '{8'd127, 16383, 1'b1};
        tbl[2] = '{8'd0,   127,   1'b1};
        tbl[3] = '{8'd1,   255,   1'b1};
        tbl[4] = '{8'd63,  8191,  1'b1};
        tbl[5] = '{8'd200, 25727, 1'b1};
        tbl[6] = '{8'd128, 16511, 1'b1};

        reset    = 1'b1;
        cw       = 1'b0;
        enable   = 1'b0;
        tx_level = 8'd255;
        repeat (5) step();
        check("reset_amplitude", int'(amplitude), 0);
        check("reset_tx_active", int'(tx_active), 0);
        check("reset_keyed", int'(keyed), 0);
        check("reset_ramping", int'(ramping), 0);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (3) step();

        // Key down from idle through delay and rise into hold
        cw = 1'b1;
        wait_for("keyed_rise_latency", 0, 1'b1, 200, 52);
        wait_for("tx_active_after_keyed", 1, 1'b1, 10, 1);
        wait_for("tr_delay_to_ramp", 2, 1'b1, 500, 300);
        run_sb("rise", 0, 513);

        // Power-level scaling while holding full scale
        foreach (tbl[i]) begin
            tx_level = tbl[i].level;
            step();
            check($sformatf("level_%0d_amp", tbl[i].level), int'(amplitude), tbl[i].amp);
            check($sformatf("level_%0d_txa", tbl[i].level), int'(tx_active), int'(tbl[i].txa));
        end
        tx_level = 8'd255;
        step();

        // Release: debounce, linear fall, then hang
        cw = 1'b0;
        wait_for("keyed_fall_latency", 0, 1'b0, 200, 52);
        wait_for("fall_start", 2, 1'b1, 10, 1);
        run_sb("fall", 1, 513);
        wait_for("hang_time", 1, 1'b0, 25000, 19999);
        check("post_hang_amp", int'(amplitude), 0);

        // Short glitch in idle must be rejected
        seen = 0;
        cw = 1'b1;
        for (int i = 0; i < 130; i++) begin
            if (i == 30) cw = 1'b0;
            step();
            if (keyed || tx_active || amplitude != 16'd0) seen++;
        end
        check("glitch_rejected", seen, 0);

        // Re-key during fall at env 16000 resumes rise with no T/R delay
        cw = 1'b1;
        wait_for("rekey_keyed", 0, 1'b1, 200, 52);
        wait_for("rekey_txa", 1, 1'b1, 10, 1);
        wait_for("rekey_ramp", 2, 1'b1, 500, 300);
        run_sb("rekey", 2, 360);
        wait_for("rekey_reach_hold", 2, 1'b0, 1000, 254);
        step();
        check("rekey_hold_amp", int'(amplitude), 32767);

        // Reset asserted while holding
        reset = 1'b1;
        step();
        check("hold_reset_amplitude", int'(amplitude), 0);
        check("hold_reset_tx_active", int'(tx_active), 0);
        check("hold_reset_keyed", int'(keyed), 0);
        check("hold_reset_ramping", int'(ramping), 0);
        cw = 1'b0;
        step();
        reset = 1'b0;
        repeat (3) step();

        // Enable dropped mid-rise at env 8192: fall straight to idle
        cw = 1'b1;
        wait_for("drop_keyed", 0, 1'b1, 200, 52);
        wait_for("drop_txa", 1, 1'b1, 10, 1);
        wait_for("drop_ramp", 2, 1'b1, 500, 300);
        run_sb("enable_drop", 3, 262);
        check("drop_keyed_held", int'(keyed), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cw_key_shaper.md
Name: cw_key_shaper

Overview:
- Converts the raw CW key input into a shaped transmit amplitude envelope, plus a T/R control flag.
- Sits directly upstream of the Transmitter stage:
  - `amplitude` is the envelope the Transmitter applies to its CW carrier.
  - `tx_active` gates the PA / T/R switching.
- Clocked from `clock_100k` (10 us tick).
- Provides input synchronisation, debounce, T/R pre-key delay, linear rise/fall ramps, hang time and power-level scaling.

Parameters:
- DEBOUNCE_CNT, 50, consecutive stable cycles before a key change is accepted (0.5 ms).
- TR_DELAY, 300, cycles between `tx_active` assertion and ramp start (3 ms relay settle).
- STEP, 64, envelope increment/decrement per cycle during ramps.
- ENV_MAX, 32767, envelope ceiling (15-bit full scale).
- HANG_CNT, 20000, cycles `tx_active` is held after the envelope reaches zero (200 ms).

Ports:
- clock  input  1  `clock_100k` domain clock
- reset  input  1  synchronous, active-high reset
- cw  input  1  raw key, asynchronous, 1 = key down
- enable  input  1  CW mode enable, synchronous
- tx_level  input  8  power scaling, 0..255
- amplitude  output  16  scaled envelope to Transmitter, unsigned, 0..32767
- tx_active  output  1  transmit/T/R request
- keyed  output  1  debounced key state
- ramping  output  1  high in RISE or FALL

Behaviour:
- Reset (synchronous, active-high, any cycle including mid-ramp):
  - all outputs 0, envelope 0, all counters 0, synchroniser flops 0, state IDLE.
- Input conditioning:
  - `cw` passes through a 2-FF synchroniser.
  - A debounce counter runs while the synchronised input differs from `keyed`; it clears when they match.
  - When the count reaches DEBOUNCE_CNT-1, `keyed` toggles and the counter clears.
  - Total latency from a stable `cw` edge to `keyed`: 2 + DEBOUNCE_CNT cycles.
- FSM states: IDLE, DELAY, RISE, HOLD, FALL, HANG.
  - IDLE:
    - `tx_active`=0, env=0.
    - `keyed`=1 and `enable`=1 -> DELAY; `tx_active`=1 on the same edge; delay counter loads 0.
  - DELAY:
    - Counter increments; at TR_DELAY-1 -> RISE.
    - `keyed`=0 -> HANG, with hang counter cleared.
    - `enable`=0 -> IDLE.
  - RISE:
    - env <= min(env+STEP, ENV_MAX); reaching ENV_MAX -> HOLD.
    - `keyed`=0 or `enable`=0 -> FALL from the current env, no discontinuity.
  - HOLD:
    - env=ENV_MAX.
    - `keyed`=0 or `enable`=0 -> FALL.
  - FALL:
    - env <= max(env-STEP, 0).
    - On the cycle env becomes 0: -> HANG if `enable`=1, else -> IDLE (`tx_active` drops).
    - `keyed`=1 and `enable`=1 during FALL -> RISE from the current env; no TR delay, since `tx_active` is still high.
  - HANG:
    - env=0, `tx_active`=1, hang counter increments.
    - `keyed`=1 and `enable`=1 -> RISE immediately; counter cleared.
    - Counter at HANG_CNT-1 -> IDLE, `tx_active`=0.
    - `enable`=0 -> IDLE.
- Saturation arithmetic:
  - Uses a 16-bit intermediate, so env never wraps.
  - The final ramp step is truncated to hit ENV_MAX / 0 exactly.
- Ramp length: ceil(ENV_MAX/STEP) cycles; with defaults, 512 cycles = 5.12 ms each way.
- Output scaling:
  - amplitude <= (env * (tx_level+1)) >> 8, registered.
  - 1-cycle latency after env; result fits 16 bits, max 32767.
  - `tx_level` changes take effect on the next cycle; no smoothing.
- `ramping` is registered with the state; it is high exactly in RISE and FALL.
- Simultaneous events:
  - Inside RISE/HOLD/FALL, `enable` falling has priority over key changes.
  - Inside DELAY/HANG, `enable`=0 wins over a key press.
  - A debounce toggle and a state transition in the same cycle: the FSM sees the new `keyed` on the following cycle.

Test Plan:
- Reset then `enable`=1, `tx_level`=255, `cw` high for 2000 cycles:
  - `keyed` rises 52 cycles after `cw`.
  - `tx_active` rises on the next cycle.
  - `amplitude` starts rising 300 cycles later.
  - `amplitude` reaches 32767 after 512 ramp cycles plus 1 output latency.
- Release `cw` from HOLD:
  - `keyed` falls after 52 cycles.
  - `amplitude` falls linearly by 64 per cycle to 0 in 512 cycles.
  - `tx_active` stays 1 for 20000 more cycles, then 0.
- `cw` glitch of 30 cycles in IDLE:
  - `keyed`, `tx_active` and `amplitude` all stay 0.
- Re-key during FALL at env=16000:
  - Next state RISE, env continues 16064, 16128, …
  - No DELAY period; `tx_active` never drops.
- `tx_level`=127 in HOLD -> `amplitude` = 32767*128>>8 = 16383.
- Drop `enable` mid-RISE at env=8192:
  - Enters FALL; env reaches 0 after 128 cycles.
  - Goes directly to IDLE (`tx_active`=0, no hang).
- Assert `reset` in HOLD -> next cycle `amplitude`, `tx_active`, `keyed`, `ramping` all 0; state IDLE.
